weapon_heat_manager: RTL and testbench
======================================

WEAPON_HEAT_MANAGER -- requirements
Module: weapon_heat_manager

Interface
REQ-001 Parameter NUM_GUNS, default 2, number of independent gun channels.
REQ-002 Parameter HEAT_W, default 4, heat counter width; HEAT_MAX = 2^HEAT_W-1.
REQ-003 Parameter FIRE_PERIOD, default 50_000_000, clock cycles between heat increments (1 Hz at 50 MHz).
REQ-004 Parameter COOL_PERIOD, default 100_000_000, clock cycles between heat decrements (0.5 Hz).
REQ-005 Parameter RELEASE_LVL, default HEAT_MAX/2, heat at or below which an overheated gun unlocks.
REQ-006 clock  input  1  system clock, 50 MHz DE2 clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start_game  input  1  synchronous game-start pulse; clears all heat.
REQ-009 shoot  input  NUM_GUNS  per-gun trigger held; bit i drives gun i.
REQ-010 heat  output  NUM_GUNS*HEAT_W  per-gun heat, gun i at bits [i*HEAT_W +: HEAT_W].
REQ-011 overheated  output  NUM_GUNS  per-gun lockout flag.
REQ-012 fire_pulse  output  NUM_GUNS  one-cycle strobe per accepted shot.

Function
REQ-013 One shared fire tick, asserted one cycle every FIRE_PERIOD cycles: down-counter loaded with FIRE_PERIOD-1, tick when counter is 0, reload on that cycle.
REQ-014 One shared cool tick, same rule with COOL_PERIOD.
REQ-015 Tick counters shall have width $clog2(PERIOD) and shall not wrap to an all-ones value; reload is the only path out of 0.
REQ-016 Per-gun FSM states: READY (heat < HEAT_MAX, unlocked) and LOCKED.
REQ-017 READY, fire tick, shoot[i]=1: heat[i] += 1, fire_pulse[i]=1 that cycle (registered, asserted the cycle after the tick).
REQ-018 READY, heat reaching HEAT_MAX by an increment: transition to LOCKED on the same edge; the shot that reaches HEAT_MAX still pulses fire_pulse.
REQ-019 LOCKED: shoot[i] ignored, no fire_pulse, heat never increments.
REQ-020 Cool tick decrements heat[i] by 1 when heat[i] > 0 and either state is LOCKED or shoot[i]=0; saturates at 0, never wraps.
REQ-021 LOCKED to READY when a decrement makes heat[i] <= RELEASE_LVL; same edge.
REQ-022 overheated[i] = 1 exactly while state is LOCKED (registered).
REQ-023 Simultaneous fire and cool tick in READY with shoot[i]=1: increment only; with shoot[i]=0: decrement only.
REQ-024 start_game=1: all heat to 0, all guns READY, overheated and fire_pulse to 0, both tick counters reloaded; overrides ticks the same cycle.
REQ-025 Channels fully independent; only the ticks are shared.
REQ-026 Heat arithmetic at HEAT_W bits; no increment above HEAT_MAX.

Reset
REQ-027 reset=0 asynchronously forces: heat=0, overheated=0, fire_pulse=0, all FSMs READY, tick counters at PERIOD-1.
REQ-028 Reset deassertion mid-period: first fire tick exactly FIRE_PERIOD cycles after the first active edge.

Structure
REQ-029 Package starflux_pkg holds the gun-state enum (READY, LOCKED) and default period constants.
REQ-030 Sub-module tick_gen (parameter PERIOD; ports clock, reset, restart, tick), instantiated twice.
REQ-031 Per-gun logic in a generate loop over NUM_GUNS.

Verification (bench params: NUM_GUNS=2, HEAT_W=4, FIRE_PERIOD=4, COOL_PERIOD=8, RELEASE_LVL=7)
REQ-032 Hold shoot=2'b01 for 60 cycles from reset -> heat0 climbs 1 per 4 cycles, reaches 15, overheated0=1, fire_pulse0 exactly 15 pulses; heat1 stays 0.
REQ-033 From heat0=15 LOCKED, keep shoot0=1 -> heat0 drops 1 per 8 cycles, no fire_pulse; overheated0 clears on the decrement to 7; next fire tick raises heat0 to 8.
REQ-034 heat0=3, shoot0=0 for 40 cycles -> heat0 reaches 0 after 3 cool ticks and stays 0.
REQ-035 Cycle where both ticks coincide, shoot=2'b10, heat={5,5} -> heat1=6 with a pulse, heat0=4.
REQ-036 start_game pulse with heat={15,9}, gun0 LOCKED -> next cycle heat={0,0}, overheated=0; next fire tick 4 cycles later.
REQ-037 reset=0 asserted mid-period -> outputs 0 immediately without a clock edge; tick spacing restarts per REQ-028.

Source files
------------

// File: rtl/weapon_heat_manager_pkg.sv
// -----------------------------------------------------------------------------
// starflux_pkg
// Shared types and constants for the weapon heat manager.
//   gun_state_t      : per-gun lockout state (READY / LOCKED)
//   DEF_FIRE_PERIOD  : default clocks between heat increments (1 Hz at 50 MHz)
//   DEF_COOL_PERIOD  : default clocks between heat decrements (0.5 Hz at 50 MHz)
// -----------------------------------------------------------------------------
package starflux_pkg;

   typedef enum logic {
      READY  = 1'b0,
      LOCKED = 1'b1
   } gun_state_t;

   localparam int DEF_FIRE_PERIOD = 50_000_000;
   localparam int DEF_COOL_PERIOD = 100_000_000;

endpackage : starflux_pkg

// File: rtl/weapon_heat_manager_if.sv
// -----------------------------------------------------------------------------
// weapon_heat_manager_if
// Game-side bundle of the heat manager.
//   start_game  : synchronous pulse, clears all heat and lockouts
//   shoot       : per-gun trigger level, bit i drives gun i
//   heat        : per-gun heat, gun i at [i*HEAT_W +: HEAT_W]
//   overheated  : per-gun lockout flag
//   fire_pulse  : per-gun one-cycle strobe for each accepted shot
// master = game controller side, slave = heat manager side.
// -----------------------------------------------------------------------------
interface weapon_heat_manager_if #(
   parameter int NUM_GUNS = 2,
   parameter int HEAT_W   = 4
);

   logic                         start_game;
   logic [NUM_GUNS-1:0]          shoot;
   logic [NUM_GUNS*HEAT_W-1:0]   heat;
   logic [NUM_GUNS-1:0]          overheated;
   logic [NUM_GUNS-1:0]          fire_pulse;

   modport master (
      output start_game,
      output shoot,
      input  heat,
      input  overheated,
      input  fire_pulse
   );

   modport slave (
      input  start_game,
      input  shoot,
      output heat,
      output overheated,
      output fire_pulse
   );

endinterface : weapon_heat_manager_if

// File: rtl/weapon_heat_manager_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running period strobe. A down-counter starts at PERIOD-1; tick is high
// for the single cycle in which the counter sits at 0, and the counter reloads
// on that same edge. restart reloads immediately.
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-low; counter to PERIOD-1
//   restart : synchronous reload to PERIOD-1
//   tick    : one-cycle strobe every PERIOD cycles
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int PERIOD = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Reload is the only way out of 0, so the counter never wraps to all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (restart || cnt_q == '0) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == '0);

endmodule : tick_gen

// File: rtl/weapon_heat_manager.sv
// -----------------------------------------------------------------------------
// weapon_heat_manager
// Per-gun heat tracking with overheat lockout. Two shared strobes (fire, cool)
// pace every gun; each gun runs its own READY/LOCKED FSM.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave side of weapon_heat_manager_if (start_game, shoot in;
//           heat, overheated, fire_pulse out)
// A held trigger in READY gains one heat per fire tick and strobes fire_pulse
// on the edge that applies it. Reaching full heat locks the gun; cool ticks
// then bleed heat until it falls to RELEASE_LVL, which unlocks it.
// -----------------------------------------------------------------------------
module weapon_heat_manager
   import starflux_pkg::*;
#(
   parameter int NUM_GUNS    = 2,
   parameter int HEAT_W      = 4,
   parameter int FIRE_PERIOD = DEF_FIRE_PERIOD,
   parameter int COOL_PERIOD = DEF_COOL_PERIOD,
   parameter int RELEASE_LVL = (2**HEAT_W - 1) / 2
) (
   input  logic                 clock,
   input  logic                 reset,
   weapon_heat_manager_if.slave bus
);

   localparam logic [HEAT_W-1:0] HEAT_MAX = '1;
   localparam logic [HEAT_W-1:0] REL_LVL  = HEAT_W'(RELEASE_LVL);

   logic              fire_tick;
   logic              cool_tick;
   logic [HEAT_W-1:0] heat_w  [NUM_GUNS];
   logic              ovh_w   [NUM_GUNS];
   logic              pulse_w [NUM_GUNS];

   // start_game also restarts both tick phases so a new game starts cleanly.
   tick_gen #(.PERIOD(FIRE_PERIOD)) u_fire_tick (
      .clock   (clock),
      .reset   (reset),
      .restart (bus.start_game),
      .tick    (fire_tick)
   );

   tick_gen #(.PERIOD(COOL_PERIOD)) u_cool_tick (
      .clock   (clock),
      .reset   (reset),
      .restart (bus.start_game),
      .tick    (cool_tick)
   );

   for (genvar g = 0; g < NUM_GUNS; g++) begin : g_gun
      gun_state_t        state_q, state_d;
      logic [HEAT_W-1:0] heat_q,  heat_d;
      logic              pulse_q, pulse_d;

      always_comb begin
         state_d = state_q;
         heat_d  = heat_q;
         pulse_d = 1'b0;
         if (bus.start_game) begin
            state_d = READY;
            heat_d  = '0;
         end else begin
            unique case (state_q)
               READY: begin
                  // A held trigger blocks cooling; an idle one lets it cool.
                  if (bus.shoot[g]) begin
                     if (fire_tick && heat_q != HEAT_MAX) begin
                        heat_d  = heat_q + HEAT_W'(1);
                        pulse_d = 1'b1;
                        if (heat_d == HEAT_MAX) begin
                           state_d = LOCKED;
                        end
                     end
                  end else if (cool_tick && heat_q != '0) begin
                     heat_d = heat_q - HEAT_W'(1);
                  end
               end
               LOCKED: begin
                  if (cool_tick && heat_q != '0) begin
                     heat_d = heat_q - HEAT_W'(1);
                     if (heat_d <= REL_LVL) begin
                        state_d = READY;
                     end
                  end
               end
               default: begin
                  state_d = READY;
               end
            endcase
         end
      end

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            state_q <= READY;
            heat_q  <= '0;
            pulse_q <= 1'b0;
         end else begin
            state_q <= state_d;
            heat_q  <= heat_d;
            pulse_q <= pulse_d;
         end
      end

      assign heat_w[g]  = heat_q;
      assign ovh_w[g]   = (state_q == LOCKED);
      assign pulse_w[g] = pulse_q;
   end

   always_comb begin
      bus.heat       = '0;
      bus.overheated = '0;
      bus.fire_pulse = '0;
      for (int i = 0; i < NUM_GUNS; i++) begin
         bus.heat[i*HEAT_W +: HEAT_W] = heat_w[i];
         bus.overheated[i]            = ovh_w[i];
         bus.fire_pulse[i]            = pulse_w[i];
      end
   end

endmodule : weapon_heat_manager

// File: tb/tb_weapon_heat_manager.sv
// -----------------------------------------------------------------------------
// tb_weapon_heat_manager
// Directed scenarios for NUM_GUNS=2, HEAT_W=4, FIRE_PERIOD=4, COOL_PERIOD=8,
// RELEASE_LVL=7. Expected output snapshots are queued with the edge count
// (posedges since reset release) at which they must hold; a monitor samples
// on the falling edge and pops each entry when its edge arrives. Entries with
// edge 0 are taken while reset is held, right after it asserts.
// -----------------------------------------------------------------------------
module tb_weapon_heat_manager;

   localparam int NG = 2;
   localparam int HW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   weapon_heat_manager_if #(.NUM_GUNS(NG), .HEAT_W(HW)) bus ();

   weapon_heat_manager #(
      .NUM_GUNS    (NG),
      .HEAT_W      (HW),
      .FIRE_PERIOD (4),
      .COOL_PERIOD (8),
      .RELEASE_LVL (7)
   ) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [7:0]  seg;
      logic [15:0] cyc;
      logic [7:0]  heat;
      logic [1:0]  ovh;
      logic [1:0]  pulse;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   edge_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   // Monitor: compare every expectation whose edge has come.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= edge_cnt) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (int'(mon_e.cyc) != edge_cnt) begin
            failures++;
            $display("FAIL missed seg=%0d cyc=%0d got_edge=%0d", mon_e.seg, mon_e.cyc, edge_cnt);
         end else if (bus.heat !== mon_e.heat || bus.overheated !== mon_e.ovh ||
                      bus.fire_pulse !== mon_e.pulse) begin
            failures++;
            $display("FAIL snapshot seg=%0d cyc=%0d heat got=%h want=%h ovh got=%b want=%b pulse got=%b want=%b",
                     mon_e.seg, mon_e.cyc, bus.heat, mon_e.heat, bus.overheated, mon_e.ovh,
                     bus.fire_pulse, mon_e.pulse);
         end
      end
   end

   task automatic push(input int seg, input int cyc, input logic [7:0] h,
                       input logic [1:0] o, input logic [1:0] p);
      exp_t e;
      e.seg   = 8'(seg);
      e.cyc   = 16'(cyc);
      e.heat  = h;
      e.ovh   = o;
      e.pulse = p;
      exp_q.push_back(e);
   endtask

   // Assert reset a few ns after a rising edge (mid-period), expect zeros at
   // the following falling edge with no rising edge in between.
   task automatic do_reset(input int seg, input logic [1:0] sh);
      @(posedge clk);
      #3;
      rst_n          = 1'b0;
      bus.start_game = 1'b0;
      bus.shoot      = sh;
      push(seg, 0, 8'h00, 2'b00, 2'b00);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
      if (exp_q.size() > 0) begin
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
         $fatal(1, "scoreboard stalled");
      end
   endtask

   int         sa_h;
   logic [3:0] sa_h4;
   logic       sa_o;
   logic       sa_p;

   initial begin
      bus.start_game = 1'b0;
      bus.shoot      = 2'b00;

      // Seg 1: gun0 held from reset, climbs to lockout, cools, unlocks, fires.
      do_reset(1, 2'b01);
      for (int e = 1; e <= 124; e++) begin
         if (e <= 60) begin
            sa_h = e / 4;  sa_o = (e == 60); sa_p = (e % 4 == 0);
         end else if (e < 64) begin
            sa_h = 15;     sa_o = 1'b1;      sa_p = 1'b0;
         end else if (e < 120) begin
            sa_h = 15 - ((e - 64) / 8 + 1); sa_o = 1'b1; sa_p = 1'b0;
         end else if (e < 124) begin
            sa_h = 7;      sa_o = 1'b0;      sa_p = 1'b0;
         end else begin
            sa_h = 8;      sa_o = 1'b0;      sa_p = 1'b1;
         end
         sa_h4 = sa_h[3:0];
         push(1, e, {4'h0, sa_h4}, {1'b0, sa_o}, {1'b0, sa_p});
      end
      wait_drain(300);

      // Seg 2: gun0 to 3, release trigger, cools to 0 and holds.
      do_reset(2, 2'b01);
      for (int e = 12; e <= 52; e++) begin
         sa_h  = (e < 16) ? 3 : (e < 24) ? 2 : (e < 32) ? 1 : 0;
         sa_h4 = sa_h[3:0];
         push(2, e, {4'h0, sa_h4}, 2'b00, (e == 12) ? 2'b01 : 2'b00);
      end
      repeat (12) @(posedge clk);
      #1 bus.shoot = 2'b00;
      wait_drain(200);

      // Seg 3: both guns at 5, coincident ticks with shoot=10.
      do_reset(3, 2'b11);
      push(3, 20, 8'h55, 2'b00, 2'b11);
      push(3, 21, 8'h55, 2'b00, 2'b00);
      push(3, 24, 8'h64, 2'b00, 2'b10);
      push(3, 25, 8'h64, 2'b00, 2'b00);
      repeat (20) @(posedge clk);
      #1 bus.shoot = 2'b10;
      wait_drain(200);

      // Seg 4: gun0 locked at 15, gun1 at 9, then start_game.
      do_reset(4, 2'b01);
      push(4, 24, 8'h06, 2'b00, 2'b01);
      push(4, 60, 8'h9F, 2'b01, 2'b11);
      push(4, 61, 8'h00, 2'b00, 2'b00);
      push(4, 64, 8'h00, 2'b00, 2'b00);
      push(4, 65, 8'h11, 2'b00, 2'b11);
      repeat (24) @(posedge clk);
      #1 bus.shoot = 2'b11;
      repeat (36) @(posedge clk);
      #1 bus.start_game = 1'b1;
      @(posedge clk);
      #1 bus.start_game = 1'b0;
      wait_drain(200);

      // Seg 5: async reset from a non-zero state.
      do_reset(5, 2'b00);
      wait_drain(50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_weapon_heat_manager
